// File: rtl/conv2_sched.sv
// Conv2 layer scheduler: streams the feature map once per filter group into the
// line buffers, tracks returned windows and sequences passes through the layer.
module conv2_sched #(
  parameter int  IMG_W     = 12,
  parameter int  K_SIZE    = 5,
  parameter int  NUM_PASS  = 4,
  parameter int  ADDR_BITS = 8,
  localparam int PASS_W    = (NUM_PASS > 1) ? $clog2(NUM_PASS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 out_ready,
  input  logic                 win_valid,
  output logic                 fm_rd_en,
  output logic [ADDR_BITS-1:0] fm_rd_addr,
  output logic                 lb_valid,
  output logic [PASS_W-1:0]    pass_idx,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  localparam int NPIX   = IMG_W * IMG_W;
  localparam int OUT_W  = IMG_W - K_SIZE + 1;
  localparam int WEXP   = OUT_W * OUT_W;
  localparam int WCNT_W = $clog2(NPIX + 1) + 1;

  localparam logic [ADDR_BITS-1:0] LAST_PIX   = ADDR_BITS'(NPIX - 1);
  localparam logic [WCNT_W-1:0]    WEXP_C     = WCNT_W'(WEXP);
  localparam logic [PASS_W-1:0]    LAST_PASS  = PASS_W'(NUM_PASS - 1);
  localparam logic [1:0]           DRAIN_LAST = 2'd3;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FEED  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_NEXT  = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]           state_q,     state_d;
  logic [ADDR_BITS-1:0] pix_cnt_q,   pix_cnt_d;
  logic [WCNT_W-1:0]    win_cnt_q,   win_cnt_d;
  logic [1:0]           drain_cnt_q, drain_cnt_d;
  logic [PASS_W-1:0]    pass_q,      pass_d;
  logic                 err_q,       err_d;
  logic                 lb_valid_q,  lb_valid_d;

  logic rd_en;
  logic count_win;
  logic win_full;
  logic drain_exit;

  assign rd_en      = (state_q == S_FEED) && out_ready;
  assign count_win  = win_valid && ((state_q == S_FEED) || (state_q == S_DRAIN));
  assign win_full   = (win_cnt_q == WEXP_C);
  // Registered count is compared, so the window riding on the last lb_valid is seen one cycle later.
  assign drain_exit = win_full || (drain_cnt_q == DRAIN_LAST);

  always_comb begin
    state_d     = state_q;
    pix_cnt_d   = pix_cnt_q;
    win_cnt_d   = win_cnt_q;
    drain_cnt_d = drain_cnt_q;
    pass_d      = pass_q;
    err_d       = err_q;
    lb_valid_d  = rd_en;

    // Saturate so a stuck win_valid can never wrap back onto the expected count.
    if (count_win && (win_cnt_q != '1)) begin
      win_cnt_d = win_cnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_FEED;
          pix_cnt_d = '0;
          win_cnt_d = '0;
          pass_d    = '0;
          err_d     = 1'b0;
        end else if (win_valid) begin
          err_d = 1'b1;
        end
      end
      S_FEED: begin
        if (rd_en) begin
          if (pix_cnt_q == LAST_PIX) begin
            pix_cnt_d   = '0;
            drain_cnt_d = '0;
            state_d     = S_DRAIN;
          end else begin
            pix_cnt_d = pix_cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        drain_cnt_d = drain_cnt_q + 1'b1;
        if (drain_exit) begin
          state_d = S_NEXT;
          if (!win_full) begin
            err_d = 1'b1;
          end
        end
      end
      S_NEXT: begin
        if (pass_q == LAST_PASS) begin
          state_d = S_FIN;
        end else begin
          pass_d    = pass_q + 1'b1;
          pix_cnt_d = '0;
          win_cnt_d = '0;
          state_d   = S_FEED;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
        if (win_valid) begin
          err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pix_cnt_q   <= '0;
      win_cnt_q   <= '0;
      drain_cnt_q <= '0;
      pass_q      <= '0;
      err_q       <= 1'b0;
      lb_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_cnt_q   <= pix_cnt_d;
      win_cnt_q   <= win_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      pass_q      <= pass_d;
      err_q       <= err_d;
      lb_valid_q  <= lb_valid_d;
    end
  end

  assign fm_rd_en   = rd_en;
  assign fm_rd_addr = pix_cnt_q;
  assign lb_valid   = lb_valid_q;
  assign pass_idx   = pass_q;
  assign busy       = (state_q != S_IDLE) && (state_q != S_FIN);
  assign done       = (state_q == S_FIN);
  assign err        = err_q;

endmodule

// File: tb/tb_conv2_sched.sv
// Bench for conv2_sched: a behavioural line-buffer model returns windows, and
// each scenario is compared against the layer's expected stream and timing.
`timescale 1ns/1ps
module tb_conv2_sched;

  localparam int IMG_W     = 12;
  localparam int K_SIZE    = 5;
  localparam int NUM_PASS  = 4;
  localparam int ADDR_BITS = 8;
  localparam int NPIX      = IMG_W * IMG_W;
  localparam int WEXP      = (IMG_W - K_SIZE + 1) * (IMG_W - K_SIZE + 1);
  localparam int NREAD     = NPIX * NUM_PASS;
  localparam int T_NOM     = NUM_PASS * (NPIX + 3) + 1;
  localparam int T_LIMIT   = T_NOM + 100;

  logic clk = 1'b0;
  logic rst, start, out_ready, win_valid;
  logic fm_rd_en, lb_valid, busy, done, err;
  logic [ADDR_BITS-1:0] fm_rd_addr;
  logic [1:0] pass_idx;

  int n_assert = 0;
  int n_fail   = 0;

  conv2_sched #(.IMG_W(IMG_W), .K_SIZE(K_SIZE), .NUM_PASS(NUM_PASS), .ADDR_BITS(ADDR_BITS)) dut (
    .clk(clk), .rst(rst), .start(start), .out_ready(out_ready), .win_valid(win_valid),
    .fm_rd_en(fm_rd_en), .fm_rd_addr(fm_rd_addr), .lb_valid(lb_valid),
    .pass_idx(pass_idx), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Line-buffer model: a window completes when the pixel just written closes a KxK block.
  logic lb_clr = 1'b0;
  logic spur   = 1'b0;
  int   drop_pass = -1;
  int   lb_cnt = 0;
  int   lb_pix, lb_pass;
  assign lb_pix  = lb_cnt % NPIX;
  assign lb_pass = lb_cnt / NPIX;

  always @(posedge clk) begin
    if (lb_clr) lb_cnt <= 0;
    else if (lb_valid) lb_cnt <= lb_cnt + 1;
  end

  always_comb begin
    win_valid = spur;
    if (lb_valid && (lb_pix / IMG_W) >= K_SIZE - 1 && (lb_pix % IMG_W) >= K_SIZE - 1 &&
        !(lb_pass == drop_pass && lb_pix == (K_SIZE - 1) * IMG_W + K_SIZE - 1))
      win_valid = 1'b1;
  end

  int   q_addr[$], q_pass[$], q_wpass[$], stall_addr_q[$];
  int   lbv_n, done_cyc, done_n, busy_gap, stall_lbv;
  logic err_c1, err_done;

  // Runs one layer from an IDLE start; cycle 0 is the start cycle.
  task automatic run_layer(input int stall_at, input int stall_len, input int xs1,
                           input int xs2, input int abort_rd);
    int c, n_rd, stalled;
    logic rdy;
    q_addr.delete(); q_pass.delete(); q_wpass.delete(); stall_addr_q.delete();
    lbv_n = 0; done_cyc = -1; done_n = 0; busy_gap = 0; stall_lbv = 0;
    err_c1 = 1'bx; err_done = 1'bx;
    @(negedge clk);
    lb_clr = 1'b1; start = 1'b1; out_ready = 1'b1;
    c = 0; n_rd = 0; stalled = 0;
    while (c < T_LIMIT) begin
      @(negedge clk);
      c++;
      lb_clr = 1'b0;
      start  = (c == xs1) || (c == xs2);
      rdy    = !(n_rd == stall_at && stalled < stall_len);
      out_ready = rdy;
      if (!rdy) stalled++;
      if (n_rd == abort_rd) begin
        rst = 1'b1;
        break;
      end
      #1;
      if (c == 1) err_c1 = err;
      if (fm_rd_en) begin
        q_addr.push_back(int'(fm_rd_addr));
        q_pass.push_back(int'(pass_idx));
        n_rd++;
      end
      if (!rdy) stall_addr_q.push_back(int'(fm_rd_addr));
      if (lb_valid) begin
        lbv_n++;
        if (!rdy) stall_lbv++;
      end
      if (win_valid) q_wpass.push_back(int'(pass_idx));
      if (done) begin
        done_n++;
        if (done_cyc < 0) begin
          done_cyc = c;
          err_done = err;
        end
      end else if (!busy && done_cyc < 0) begin
        busy_gap++;
      end
      if (done_cyc >= 0 && c >= done_cyc + 2) break;
    end
    start = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_assert++; if (fm_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b expected 0", fm_rd_en); end
    n_assert++; if (lb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_lb_valid: got %b expected 0", lb_valid); end
    n_assert++; if (fm_rd_addr !== '0) begin n_fail++; $display("FAIL reset_addr: got %0d expected 0", fm_rd_addr); end
    n_assert++; if (pass_idx !== 2'd0) begin n_fail++; $display("FAIL reset_pass: got %0d expected 0", pass_idx); end
    n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_assert++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    rst = 1'b0;
  endtask

  task automatic test_nominal;
    run_layer(-1, 0, -1, -1, -1);
    n_assert++; if (q_addr.size() !== NREAD) begin n_fail++; $display("FAIL nom_read_count: got %0d expected %0d", q_addr.size(), NREAD); end
    for (int k = 0; k < q_addr.size() && k < NREAD; k++) begin
      n_assert++;
      if (q_addr[k] !== k % NPIX || q_pass[k] !== k / NPIX) begin
        n_fail++;
        $display("FAIL nom_read[%0d]: got addr %0d pass %0d expected addr %0d pass %0d", k, q_addr[k], q_pass[k], k % NPIX, k / NPIX);
      end
    end
    n_assert++; if (q_wpass.size() !== NUM_PASS * WEXP) begin n_fail++; $display("FAIL nom_windows: got %0d expected %0d", q_wpass.size(), NUM_PASS * WEXP); end
    for (int w = 0; w < q_wpass.size() && w < NUM_PASS * WEXP; w++) begin
      n_assert++;
      if (q_wpass[w] !== w / WEXP) begin n_fail++; $display("FAIL nom_win_pass[%0d]: got %0d expected %0d", w, q_wpass[w], w / WEXP); end
    end
    n_assert++; if (lbv_n !== NREAD) begin n_fail++; $display("FAIL nom_lb_valid: got %0d expected %0d", lbv_n, NREAD); end
    n_assert++; if (done_cyc !== T_NOM) begin n_fail++; $display("FAIL nom_done_cycle: got %0d expected %0d", done_cyc, T_NOM); end
    n_assert++; if (done_n !== 1) begin n_fail++; $display("FAIL nom_done_pulses: got %0d expected 1", done_n); end
    n_assert++; if (busy_gap !== 0) begin n_fail++; $display("FAIL nom_busy_gap: got %0d expected 0", busy_gap); end
    n_assert++; if (err_done !== 1'b0) begin n_fail++; $display("FAIL nom_err: got %b expected 0", err_done); end
  endtask

  task automatic test_backpressure(input int stall_at, input int len, input string tag);
    int bad;
    run_layer(stall_at, len, -1, -1, -1);
    bad = 0;
    for (int k = 0; k < q_addr.size(); k++)
      if (q_addr[k] !== k % NPIX || q_pass[k] !== k / NPIX) bad++;
    n_assert++; if (q_addr.size() !== NREAD || bad !== 0) begin n_fail++; $display("FAIL %s_stream: got %0d reads %0d bad expected %0d reads 0 bad", tag, q_addr.size(), bad, NREAD); end
    bad = 0;
    foreach (stall_addr_q[i]) if (stall_addr_q[i] !== stall_at % NPIX) bad++;
    n_assert++; if (stall_addr_q.size() !== len || bad !== 0) begin n_fail++; $display("FAIL %s_hold_addr: got %0d cycles %0d off expected %0d cycles at %0d", tag, stall_addr_q.size(), bad, len, stall_at % NPIX); end
    n_assert++; if (stall_lbv !== 1) begin n_fail++; $display("FAIL %s_trailing_lb: got %0d expected 1", tag, stall_lbv); end
    n_assert++; if (done_cyc !== T_NOM + len) begin n_fail++; $display("FAIL %s_done_cycle: got %0d expected %0d", tag, done_cyc, T_NOM + len); end
    n_assert++; if (err_done !== 1'b0) begin n_fail++; $display("FAIL %s_err: got %b expected 0", tag, err_done); end
  endtask

  task automatic test_random_backpressure;
    int p, off, len;
    for (int it = 0; it < 3; it++) begin
      p   = $urandom_range(0, NUM_PASS - 1);
      off = $urandom_range(1, NPIX - 1);
      len = $urandom_range(1, 16);
      test_backpressure(p * NPIX + off, len, "rand");
    end
  endtask

  task automatic test_spurious_idle;
    int act;
    @(negedge clk); spur = 1'b1;
    @(negedge clk); spur = 1'b0;
    #1;
    n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL spur_err: got %b expected 1", err); end
    act = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy || fm_rd_en || lb_valid || done) act++;
      @(negedge clk); #1;
    end
    n_assert++; if (act !== 0) begin n_fail++; $display("FAIL spur_stays_idle: got %0d active cycles expected 0", act); end
  endtask

  task automatic test_short_windows;
    drop_pass = 2;
    run_layer(-1, 0, -1, -1, -1);
    drop_pass = -1;
    n_assert++; if (q_wpass.size() !== NUM_PASS * WEXP - 1) begin n_fail++; $display("FAIL short_windows: got %0d expected %0d", q_wpass.size(), NUM_PASS * WEXP - 1); end
    n_assert++; if (done_cyc !== T_NOM + 2) begin n_fail++; $display("FAIL short_done_cycle: got %0d expected %0d", done_cyc, T_NOM + 2); end
    n_assert++; if (done_n !== 1) begin n_fail++; $display("FAIL short_done_pulses: got %0d expected 1", done_n); end
    n_assert++; if (err_done !== 1'b1) begin n_fail++; $display("FAIL short_err_at_done: got %b expected 1", err_done); end
    repeat (5) @(negedge clk);
    #1;
    n_assert++; if (err !== 1'b1) begin n_fail++; $display("FAIL short_err_sticky: got %b expected 1", err); end
  endtask

  task automatic test_start_ignored;
    int act;
    run_layer(-1, 0, 100, T_NOM, -1);
    n_assert++; if (err_c1 !== 1'b0) begin n_fail++; $display("FAIL ign_err_cleared: got %b expected 0", err_c1); end
    n_assert++; if (done_cyc !== T_NOM) begin n_fail++; $display("FAIL ign_done_cycle: got %0d expected %0d", done_cyc, T_NOM); end
    n_assert++; if (q_addr.size() !== NREAD) begin n_fail++; $display("FAIL ign_read_count: got %0d expected %0d", q_addr.size(), NREAD); end
    act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      if (busy || fm_rd_en || done) act++;
    end
    n_assert++; if (act !== 0) begin n_fail++; $display("FAIL ign_second_run: got %0d active cycles expected 0", act); end
  endtask

  task automatic test_reset_midpass;
    int bad;
    run_layer(-1, 0, -1, -1, NPIX + 77);
    n_assert++; if (q_addr.size() !== NPIX + 77) begin n_fail++; $display("FAIL abort_reads: got %0d expected %0d", q_addr.size(), NPIX + 77); end
    @(negedge clk); #1;
    n_assert++; if (fm_rd_en !== 1'b0 || lb_valid !== 1'b0) begin n_fail++; $display("FAIL abort_rd_lb: got rd %b lb %b expected 0 0", fm_rd_en, lb_valid); end
    n_assert++; if (fm_rd_addr !== '0 || pass_idx !== 2'd0) begin n_fail++; $display("FAIL abort_addr_pass: got %0d %0d expected 0 0", fm_rd_addr, pass_idx); end
    n_assert++; if (busy !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL abort_flags: got busy %b done %b err %b expected 0 0 0", busy, done, err); end
    n_assert++; if (done_n !== 0) begin n_fail++; $display("FAIL abort_no_done: got %0d expected 0", done_n); end
    rst = 1'b0;
    run_layer(-1, 0, -1, -1, -1);
    bad = 0;
    for (int k = 0; k < q_addr.size(); k++)
      if (q_addr[k] !== k % NPIX || q_pass[k] !== k / NPIX) bad++;
    n_assert++; if (q_addr.size() !== NREAD || bad !== 0) begin n_fail++; $display("FAIL rerun_stream: got %0d reads %0d bad expected %0d reads 0 bad", q_addr.size(), bad, NREAD); end
    n_assert++; if (done_cyc !== T_NOM) begin n_fail++; $display("FAIL rerun_done_cycle: got %0d expected %0d", done_cyc, T_NOM); end
    n_assert++; if (err_done !== 1'b0) begin n_fail++; $display("FAIL rerun_err: got %b expected 0", err_done); end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b1;
    test_reset();
    test_nominal();
    test_backpressure(50, 10, "bp");
    test_random_backpressure();
    test_spurious_idle();
    test_short_windows();
    test_start_ignored();
    test_reset_midpass();
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
